writeback_stage: RTL and testbench

- Registered writeback stage for the pipelined RV32 core; replaces the purely combinational result mux.
- Holds the MEM/WB pipeline register with stall/flush.
- Formats load data (byte/half, sign/zero extension), selects the result from four sources (adds ImmExt for LUI), gates the register-file write, and counts retired instructions.

---
 rtl/writeback_stage_if.sv | 40 ++++
 rtl/writeback_stage.sv | 126 ++++++++++++
 tb/tb_writeback_stage.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// MEM/WB boundary bundle: M-stage fields in, W-stage results out.
// The master drives M fields and controls; the slave is the stage.
interface writeback_stage_if #(
   parameter int DATA_WIDTH = 32,
   parameter int RD_WIDTH   = 5,
   parameter int CNT_WIDTH  = 32
);
   logic                  stallW;
   logic                  flushW;
   logic                  validM;
   logic                  RegWriteM;
   logic [1:0]            ResultSrcM;
   logic [2:0]            funct3M;
   logic [RD_WIDTH-1:0]   rdM;
   logic [DATA_WIDTH-1:0] ALUoutM;
   logic [DATA_WIDTH-1:0] ReadDataM;
   logic [DATA_WIDTH-1:0] inc_PCM;
   logic [DATA_WIDTH-1:0] ImmExtM;
   logic [DATA_WIDTH-1:0] ResultW;
   logic [RD_WIDTH-1:0]   RdW;
   logic                  RegWriteW;
   logic                  validW;
   logic [CNT_WIDTH-1:0]  retire_count;

   modport master (
      output stallW, flushW, validM, RegWriteM,
      output ResultSrcM, funct3M, rdM,
      output ALUoutM, ReadDataM, inc_PCM, ImmExtM,
      input  ResultW, RdW, RegWriteW, validW,
      input  retire_count
   );

   modport slave (
      input  stallW, flushW, validM, RegWriteM,
      input  ResultSrcM, funct3M, rdM,
      input  ALUoutM, ReadDataM, inc_PCM, ImmExtM,
      output ResultW, RdW, RegWriteW, validW,
      output retire_count
   );
endinterface

// File: rtl/writeback_stage.sv
// Registered writeback: MEM/WB register, load formatting,
// result select, write-enable gating and retire counting.
module writeback_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int RD_WIDTH   = 5,
   parameter int CNT_WIDTH  = 32
) (
   input logic             clk,
   input logic             rst_n,
   writeback_stage_if.slave wb
);
   logic                  valid_q, valid_d;
   logic                  we_q, we_d;
   logic [1:0]            src_q, src_d;
   logic [2:0]            f3_q, f3_d;
   logic [RD_WIDTH-1:0]   rd_q, rd_d;
   logic [DATA_WIDTH-1:0] alu_q, alu_d;
   logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] imm_q, imm_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

   logic [31:0]           word;
   logic [15:0]           half;
   logic [7:0]            byte_v;
   logic [DATA_WIDTH-1:0] load_v;
   logic [DATA_WIDTH-1:0] res_v;

   // Next state: flush kills the incoming entry, stall holds,
   // the retiring entry is counted whenever W is not stalled.
   always_comb begin
      valid_d = valid_q;
      we_d    = we_q;
      src_d   = src_q;
      f3_d    = f3_q;
      rd_d    = rd_q;
      alu_d   = alu_q;
      rdat_d  = rdat_q;
      pc_d    = pc_q;
      imm_d   = imm_q;
      cnt_d   = cnt_q;
      if (valid_q && !wb.stallW)
         cnt_d = cnt_q + CNT_WIDTH'(1);
      if (wb.flushW) begin
         valid_d = 1'b0;
         we_d    = 1'b0;
      end else if (!wb.stallW) begin
         valid_d = wb.validM;
         we_d    = wb.RegWriteM;
         src_d   = wb.ResultSrcM;
         f3_d    = wb.funct3M;
         rd_d    = wb.rdM;
         alu_d   = wb.ALUoutM;
         rdat_d  = wb.ReadDataM;
         pc_d    = wb.inc_PCM;
         imm_d   = wb.ImmExtM;
      end
   end

   // W register; reset drops any in-flight entry immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         src_q   <= '0;
         f3_q    <= '0;
         rd_q    <= '0;
         alu_q   <= '0;
         rdat_q  <= '0;
         pc_q    <= '0;
         imm_q   <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         we_q    <= we_d;
         src_q   <= src_d;
         f3_q    <= f3_d;
         rd_q    <= rd_d;
         alu_q   <= alu_d;
         rdat_q  <= rdat_d;
         pc_q    <= pc_d;
         imm_q   <= imm_d;
         cnt_q   <= cnt_d;
      end
   end

   // Lane extraction from the low word using the address offset.
   always_comb begin
      word = rdat_q[31:0];
      half = alu_q[1] ? word[31:16] : word[15:0];
      case (alu_q[1:0])
         2'd0:    byte_v = word[7:0];
         2'd1:    byte_v = word[15:8];
         2'd2:    byte_v = word[23:16];
         default: byte_v = word[31:24];
      endcase
   end

   // Load formatting by funct3; unknown types pass the raw word.
   always_comb begin
      case (f3_q)
         3'b000:  load_v = DATA_WIDTH'($signed(byte_v));
         3'b100:  load_v = DATA_WIDTH'(byte_v);
         3'b001:  load_v = DATA_WIDTH'($signed(half));
         3'b101:  load_v = DATA_WIDTH'(half);
         3'b010:  load_v = DATA_WIDTH'($signed(word));
         default: load_v = rdat_q;
      endcase
   end

   // Result select; driven even for bubbles, the write is gated.
   always_comb begin
      case (src_q)
         2'd0:    res_v = alu_q;
         2'd1:    res_v = load_v;
         2'd2:    res_v = pc_q;
         default: res_v = imm_q;
      endcase
   end

   assign wb.ResultW      = res_v;
   assign wb.RdW          = rd_q;
   assign wb.RegWriteW    = valid_q & we_q & (rd_q != '0);
   assign wb.validW       = valid_q;
   assign wb.retire_count = cnt_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: vector table with scoreboard,
// plus stall, flush, reset, wrap and bubble sequences.
module tb_writeback_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   writeback_stage_if #(.CNT_WIDTH(32)) wb ();
   writeback_stage_if #(.CNT_WIDTH(4))  w4 ();

   writeback_stage #(.CNT_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .wb(wb.slave)
   );
   writeback_stage #(.CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .wb(w4.slave)
   );

   assign w4.stallW     = wb.stallW;
   assign w4.flushW     = wb.flushW;
   assign w4.validM     = wb.validM;
   assign w4.RegWriteM  = wb.RegWriteM;
   assign w4.ResultSrcM = wb.ResultSrcM;
   assign w4.funct3M    = wb.funct3M;
   assign w4.rdM        = wb.rdM;
   assign w4.ALUoutM    = wb.ALUoutM;
   assign w4.ReadDataM  = wb.ReadDataM;
   assign w4.inc_PCM    = wb.inc_PCM;
   assign w4.ImmExtM    = wb.ImmExtM;

   typedef struct {
      logic        v;
      logic        rw;
      logic [1:0]  src;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] rdat;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] eres;
      logic        ewe;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        we;
      logic        v;
   } exp_t;

   vec_t        vt[11];
   exp_t        sb[$];
   exp_t        e;
   int          npass = 0;
   int          ntot  = 0;
   logic        mvalid = 1'b0;
   logic [31:0] mcnt = '0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic drive(vec_t x);
      wb.validM     = x.v;
      wb.RegWriteM  = x.rw;
      wb.ResultSrcM = x.src;
      wb.funct3M    = x.f3;
      wb.rdM        = x.rd;
      wb.ALUoutM    = x.alu;
      wb.ReadDataM  = x.rdat;
      wb.inc_PCM    = x.pc;
      wb.ImmExtM    = x.imm;
   endtask

   task automatic step();
      if (mvalid && !wb.stallW) mcnt = mcnt + 1;
      if (wb.flushW) mvalid = 1'b0;
      else if (!wb.stallW) mvalid = wb.validM;
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse();
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      mvalid = 1'b0;
      mcnt   = '0;
   endtask

   function automatic vec_t mk(logic v, logic rw, logic [1:0] s,
         logic [2:0] f, logic [4:0] rd, logic [31:0] a,
         logic [31:0] r, logic [31:0] p, logic [31:0] i,
         logic [31:0] er, logic ew);
      vec_t x;
      x.v = v; x.rw = rw; x.src = s; x.f3 = f; x.rd = rd;
      x.alu = a; x.rdat = r; x.pc = p; x.imm = i;
      x.eres = er; x.ewe = ew;
      return x;
   endfunction

   initial begin
      vec_t hv;
      vt[0]  = mk(1,1,0,3'b000,5, 32'h12345678,32'h0BAD0BAD,
                  32'h00000AA0,32'h0000BBB0,32'h12345678,1);
      vt[1]  = mk(1,1,1,3'b000,6, 32'h00001001,32'h80FF7F01,
                  32'h11111111,32'h22222222,32'h0000007F,1);
      vt[2]  = mk(1,1,1,3'b000,7, 32'h00001002,32'h80FF7F01,
                  32'h11111111,32'h22222222,32'hFFFFFFFF,1);
      vt[3]  = mk(1,1,1,3'b100,8, 32'h00001003,32'h80FF7F01,
                  32'h11111111,32'h22222222,32'h00000080,1);
      vt[4]  = mk(1,1,1,3'b001,9, 32'h00001002,32'h80FF7F01,
                  32'h11111111,32'h22222222,32'hFFFF80FF,1);
      vt[5]  = mk(1,1,1,3'b101,10,32'h00001000,32'h80FF7F01,
                  32'h11111111,32'h22222222,32'h00007F01,1);
      vt[6]  = mk(1,1,1,3'b010,11,32'h00001000,32'h80FF7F01,
                  32'h11111111,32'h22222222,32'h80FF7F01,1);
      vt[7]  = mk(1,1,2,3'b000,12,32'h33333333,32'h44444444,
                  32'h00000104,32'h55555555,32'h00000104,1);
      vt[8]  = mk(1,1,3,3'b000,13,32'h33333333,32'h44444444,
                  32'h66666666,32'hABCDE000,32'hABCDE000,1);
      vt[9]  = mk(1,1,0,3'b000,0, 32'h77777777,32'h44444444,
                  32'h66666666,32'h88888888,32'h77777777,0);
      vt[10] = mk(0,1,1,3'b011,3, 32'h00001001,32'h80FF7F01,
                  32'h66666666,32'h88888888,32'h80FF7F01,0);

      wb.stallW = 1'b0;
      wb.flushW = 1'b0;
      drive(mk(0,0,0,0,0,0,0,0,0,0,0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      chk("rst_validW",   64'(wb.validW),       64'(0));
      chk("rst_regwrite", 64'(wb.RegWriteW),    64'(0));
      chk("rst_rd",       64'(wb.RdW),          64'(0));
      chk("rst_result",   64'(wb.ResultW),      64'(0));
      chk("rst_count",    64'(wb.retire_count), 64'(0));

      for (int i = 0; i < 11; i++) begin
         drive(vt[i]);
         sb.push_back('{vt[i].eres, vt[i].rd, vt[i].ewe, vt[i].v});
         step();
         e = sb.pop_front();
         chk($sformatf("vec%0d_res", i), 64'(wb.ResultW), 64'(e.res));
         chk($sformatf("vec%0d_rd", i),  64'(wb.RdW),     64'(e.rd));
         chk($sformatf("vec%0d_we", i),  64'(wb.RegWriteW), 64'(e.we));
         chk($sformatf("vec%0d_v", i),   64'(wb.validW),  64'(e.v));
         chk($sformatf("vec%0d_cnt", i),
             64'(wb.retire_count), 64'(mcnt));
      end

      hv = mk(1,1,0,0,5,32'hCAFEF00D,0,0,0,0,0);
      drive(hv);
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_validW", 64'(wb.validW),       64'(0));
      chk("arst_we",     64'(wb.RegWriteW),    64'(0));
      chk("arst_res",    64'(wb.ResultW),      64'(0));
      chk("arst_rd",     64'(wb.RdW),          64'(0));
      chk("arst_cnt",    64'(wb.retire_count), 64'(0));
      mvalid = 1'b0;
      mcnt   = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      drive(mk(1,1,0,0,7,32'hCAFEF00D,0,0,0,0,0));
      step();
      drive(mk(1,1,3,0,9,32'h0,0,0,32'h5A5A5A5A,0,0));
      wb.stallW = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("stall%0d_res", i),
             64'(wb.ResultW), 64'(32'hCAFEF00D));
         chk($sformatf("stall%0d_rd", i), 64'(wb.RdW), 64'(7));
         chk($sformatf("stall%0d_we", i), 64'(wb.RegWriteW), 64'(1));
         chk($sformatf("stall%0d_cnt", i),
             64'(wb.retire_count), 64'(mcnt));
      end
      chk("stall_cnt_const", 64'(mcnt), 64'(wb.retire_count));
      wb.stallW = 1'b0;
      wb.validM = 1'b0;
      step();
      chk("unstall_cnt", 64'(wb.retire_count), 64'(1));
      chk("unstall_v",   64'(wb.validW),       64'(0));

      drive(mk(1,1,0,0,4,32'h1,0,0,0,0,0));
      step();
      wb.flushW = 1'b1;
      step();
      chk("flush_v",   64'(wb.validW),       64'(0));
      chk("flush_we",  64'(wb.RegWriteW),    64'(0));
      chk("flush_cnt", 64'(wb.retire_count), 64'(2));
      wb.flushW = 1'b0;
      step();
      drive(mk(1,1,0,0,4,32'h2,0,0,0,0,0));
      step();
      wb.flushW = 1'b1;
      wb.stallW = 1'b1;
      step();
      chk("flstall_v",   64'(wb.validW),       64'(0));
      chk("flstall_we",  64'(wb.RegWriteW),    64'(0));
      chk("flstall_cnt", 64'(wb.retire_count), 64'(mcnt));
      wb.flushW = 1'b0;
      wb.stallW = 1'b0;

      rst_pulse();
      for (int i = 0; i < 17; i++) begin
         drive(mk(1,0,0,0,1,32'(i),0,0,0,0,0));
         step();
      end
      wb.validM = 1'b0;
      step();
      chk("wrap_cnt32", 64'(wb.retire_count), 64'(17));
      chk("wrap_cnt4",  64'(w4.retire_count), 64'(1));

      rst_pulse();
      for (int i = 0; i < 10; i++) begin
         drive(mk(((i % 2) == 0),1,0,0,9,32'(i),0,0,0,0,0));
         step();
         chk($sformatf("bub%0d_we", i),
             64'(wb.RegWriteW), 64'(mvalid));
      end
      chk("bub_cnt", 64'(wb.retire_count), 64'(5));

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
